// File: rtl/rib_ex_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rib_ex_arbiter_pkg
// Shared definitions for the rib ex master-port arbiter:
//   - memory bus widths (MemAddrBus / MemBus)
//   - requester index constants (core, send coprocessor, fire coprocessor)
//   - arbiter FSM state encoding
//   - helper that turns a one-hot grant into a requester index
// ---------------------------------------------------------------------------
package rib_ex_arbiter_pkg;

    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_BUS      = 32;

    localparam logic [1:0] REQ_CORE = 2'd0;
    localparam logic [1:0] REQ_SEND = 2'd1;
    localparam logic [1:0] REQ_FIRE = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    // One-hot grant to requester index; an all-zero grant maps to core,
    // which is harmless because the caller only uses it when a grant exists.
    function automatic logic [1:0] gnt_to_idx(input logic [2:0] gnt);
        logic [1:0] idx;
        idx = REQ_CORE;
        if (gnt[REQ_SEND]) begin
            idx = REQ_SEND;
        end else if (gnt[REQ_FIRE]) begin
            idx = REQ_FIRE;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rib_ex_arbiter_rr_pick3.sv
// ---------------------------------------------------------------------------
// rib_ex_arbiter_rr_pick3
// Combinational 3-way round-robin selector (the rr_pick3 block).
// Ports:
//   req       in   [2:0]  request vector, bit index = requester index
//   last_gnt  in   [1:0]  index of the requester granted most recently
//   core_prio in   1      when set, a requesting core wins unconditionally
//   gnt       out  [2:0]  one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module rib_ex_arbiter_rr_pick3
    import rib_ex_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_gnt,
    input  logic       core_prio,
    output logic [2:0] gnt
);

    // Scan starts at the requester after last_gnt in the cyclic order
    // core -> send -> fire, so a requester that was just served goes to
    // the back of the line. The core-priority override sits in front of it.
    always_comb begin
        gnt = 3'b000;
        if (core_prio && req[REQ_CORE]) begin
            gnt[REQ_CORE] = 1'b1;
        end else begin
            case (last_gnt)
                REQ_CORE: begin
                    if      (req[REQ_SEND]) gnt[REQ_SEND] = 1'b1;
                    else if (req[REQ_FIRE]) gnt[REQ_FIRE] = 1'b1;
                    else if (req[REQ_CORE]) gnt[REQ_CORE] = 1'b1;
                end
                REQ_SEND: begin
                    if      (req[REQ_FIRE]) gnt[REQ_FIRE] = 1'b1;
                    else if (req[REQ_CORE]) gnt[REQ_CORE] = 1'b1;
                    else if (req[REQ_SEND]) gnt[REQ_SEND] = 1'b1;
                end
                default: begin
                    if      (req[REQ_CORE]) gnt[REQ_CORE] = 1'b1;
                    else if (req[REQ_SEND]) gnt[REQ_SEND] = 1'b1;
                    else if (req[REQ_FIRE]) gnt[REQ_FIRE] = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/rib_ex_arbiter.sv
// ---------------------------------------------------------------------------
// rib_ex_arbiter
// Shares the single rib ex master port between the ex stage (core), the
// send coprocessor and the fire coprocessor. One access at a time:
// IDLE picks a winner and registers its request onto the bus, ACCESS waits
// out bus_hold_i and captures read data, DONE pulses the winner's done.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   {core,send,fire}_req_i        request, held until matching done
//   {core,send,fire}_we_i         1 = write
//   {core,send,fire}_addr_i       access address
//   {core,send,fire}_wdata_i      write data
//   {core,send,fire}_done_o       one-cycle completion pulse
//   rdata_o                       read data, valid while a done is high
//   busy_o                        arbiter not idle
//   bus_req_o/we_o/addr_o/wdata_o rib_ex master outputs (registered)
//   bus_rdata_i, bus_hold_i       rib_ex read data and hold flag
// ---------------------------------------------------------------------------
module rib_ex_arbiter
    import rib_ex_arbiter_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_BUS,
    parameter int DATA_W    = MEM_BUS,
    parameter int CORE_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_i,
    input  logic              send_req_i,
    input  logic              fire_req_i,
    input  logic              core_we_i,
    input  logic              send_we_i,
    input  logic              fire_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [ADDR_W-1:0] send_addr_i,
    input  logic [ADDR_W-1:0] fire_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    input  logic [DATA_W-1:0] send_wdata_i,
    input  logic [DATA_W-1:0] fire_wdata_i,
    output logic              core_done_o,
    output logic              send_done_o,
    output logic              fire_done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_hold_i
);

    localparam logic CORE_PRIO_EN = (CORE_PRIO != 0);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [2:0]        req_vec;
    logic [2:0]        gnt;
    logic [1:0]        gnt_idx;
    logic [1:0]        winner;
    logic [1:0]        last_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req_vec = {fire_req_i, send_req_i, core_req_i};
    assign gnt_idx = gnt_to_idx(gnt);

    rib_ex_arbiter_rr_pick3 u_pick (
        .req       (req_vec),
        .last_gnt  (last_gnt),
        .core_prio (CORE_PRIO_EN),
        .gnt       (gnt)
    );

    // Route the granted requester's access fields toward the bus registers.
    always_comb begin
        sel_we    = core_we_i;
        sel_addr  = core_addr_i;
        sel_wdata = core_wdata_i;
        if (gnt[REQ_SEND]) begin
            sel_we    = send_we_i;
            sel_addr  = send_addr_i;
            sel_wdata = send_wdata_i;
        end else if (gnt[REQ_FIRE]) begin
            sel_we    = fire_we_i;
            sel_addr  = fire_addr_i;
            sel_wdata = fire_wdata_i;
        end
    end

    // FSM state register. Reset drops straight back to IDLE, which also
    // aborts any access in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: requests are only looked at in IDLE, the hold flag
    // only in ACCESS, and DONE always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:   if (|req_vec)    state_next = ARB_ACCESS;
            ARB_ACCESS: if (!bus_hold_i) state_next = ARB_DONE;
            ARB_DONE:                    state_next = ARB_IDLE;
            default:                     state_next = ARB_IDLE;
        endcase
    end

    // Output logic: done goes to whoever won the access that just ended.
    always_comb begin
        busy_o      = (state != ARB_IDLE);
        core_done_o = (state == ARB_DONE) && (winner == REQ_CORE);
        send_done_o = (state == ARB_DONE) && (winner == REQ_SEND);
        fire_done_o = (state == ARB_DONE) && (winner == REQ_FIRE);
    end

    // Bus-side registers. The request is latched once in IDLE so the bus
    // sees a stable copy for the whole ACCESS regardless of what the
    // requester does; rdata_o is only written when an access completes so
    // it keeps its last value between accesses. The round-robin pointer
    // starts at fire so the first scan order is core, send, fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            rdata_o     <= '0;
            winner      <= REQ_CORE;
            last_gnt    <= REQ_FIRE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req_vec) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= sel_we;
                        bus_addr_o  <= sel_addr;
                        bus_wdata_o <= sel_wdata;
                        winner      <= gnt_idx;
                        last_gnt    <= gnt_idx;
                    end else begin
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= '0;
                        bus_wdata_o <= '0;
                    end
                end
                ARB_ACCESS: begin
                    if (!bus_hold_i) begin
                        rdata_o   <= bus_rdata_i;
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/rib_ex_arbiter.md
Name: rib_ex_arbiter

Overview:
- Shares the core's single rib ex master port between three requesters: the ex stage (core load/store), the send coprocessor and the fire coprocessor.
- Accepts one request at a time and issues it on the bus, stretching the access while the bus hold flag is asserted. It then returns registered read data and a one-cycle done pulse to the winning requester.
- Sits inside tinyriscv between ex/send/fire and the rib_ex_* top-level ports.

Parameters:
- ADDR_W, 32, address width (MemAddrBus)
- DATA_W, 32, data width (MemBus)
- CORE_PRIO, 1, 1 = core always wins over coprocessors; 0 = pure round-robin across all three

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- core_req_i / send_req_i / fire_req_i  in  1 each  access request; held high until the matching done pulse
- core_we_i / send_we_i / fire_we_i  in  1 each  1 = write
- core_addr_i / send_addr_i / fire_addr_i  in  ADDR_W each  access address
- core_wdata_i / send_wdata_i / fire_wdata_i  in  DATA_W each  write data
- core_done_o / send_done_o / fire_done_o  out  1 each  one-cycle completion pulse
- rdata_o  out  DATA_W  read data, valid while any done_o is high
- busy_o  out  1  arbiter not IDLE
- bus_req_o  out  1  drives rib_ex_req_o
- bus_we_o  out  1  drives rib_ex_we_o
- bus_addr_o  out  ADDR_W  drives rib_ex_addr_o
- bus_wdata_o  out  DATA_W  drives rib_ex_data_o
- bus_rdata_i  in  DATA_W  from rib_ex_data_i
- bus_hold_i  in  1  rib_hold_flag_i; bus not ready this cycle

Behaviour:
- Reset:
  - state = IDLE; all done_o = 0; bus_req_o = 0, bus_we_o = 0; bus_addr_o, bus_wdata_o, rdata_o = 0; busy_o = 0.
  - Round-robin pointer last_gnt = fire, so the next scan order is core, send, fire.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req_i is high, select a winner. With CORE_PRIO=1 the core wins if it is requesting; otherwise the winner is the next requester after last_gnt in the cyclic order core -> send -> fire.
  - Register the winner's we/addr/wdata into the bus outputs, set bus_req_o = 1, update last_gnt, go to ACCESS.
  - With no request, stay in IDLE with bus outputs 0.
- ACCESS:
  - Bus outputs stay stable from the registered copy; requester inputs are ignored.
  - If bus_hold_i = 1, stay in ACCESS. Hold may persist for any number of cycles.
  - If bus_hold_i = 0:
    - capture bus_rdata_i into rdata_o (captured for writes too; don't-care);
    - clear bus_req_o and bus_we_o;
    - go to DONE.
- DONE:
  - Pulse done_o of the winner for exactly one cycle; rdata_o is valid in this cycle.
  - Return to IDLE.
  - The requester may drop or re-raise req in the same cycle; the arbiter samples requests only in IDLE.
- Latency: request sampled in IDLE at cycle 0, bus access in cycle 1, done in cycle 2 (with no hold). Peak throughput is one access per 3 cycles.
- Boundary conditions:
  - Req dropped during ACCESS: the access still completes and done still pulses.
  - Simultaneous requests are resolved only by the priority rule; losers wait, with no starvation among coprocessors. With CORE_PRIO=1 a continuously requesting core starves the coprocessors, and this is accepted by design.
  - rdata_o holds its last value between accesses.
  - Reset mid-access aborts immediately: bus_req_o = 0 and no done pulse is issued.
  - At most one done_o is high at any time; busy_o = (state != IDLE).

Decomposition:
- Shared defines (defines.v): requester index constants REQ_CORE = 0, REQ_SEND = 1, REQ_FIRE = 2; FSM state encodings ARB_IDLE, ARB_ACCESS, ARB_DONE; MemAddrBus/MemBus reused for widths.
- One sub-module is natural: rr_pick3, a combinational 3-way round-robin selector (inputs: req[2:0], last_gnt[1:0], core_prio; output: one-hot gnt[2:0]).

Test Plan:
- Single core read, addr 0x1000_0004, bus_rdata_i = 0xDEAD_BEEF, no hold -> bus_req_o high in cycle 1 with bus_addr_o = 0x1000_0004 and bus_we_o = 0; core_done_o pulses in cycle 2 with rdata_o = 0xDEAD_BEEF.
- send write, addr 0x2000_0000, data 0x1234_5678, bus_hold_i high for 3 cycles -> bus outputs stable for 4 ACCESS cycles; send_done_o pulses exactly once, in the cycle after hold drops.
- CORE_PRIO=0, all three requesting continuously -> grant order core, send, fire, core, ...; done pulses spaced 3 cycles apart.
- CORE_PRIO=1, send and fire held high, core requests once -> core is served first; then send and fire alternate.
- fire req dropped mid-ACCESS -> access completes; fire_done_o still pulses once.
- rst asserted in ACCESS -> bus_req_o = 0 in the same cycle, no done pulse, busy_o = 0; after release, a core request is granted first.
